// File: rtl/axis_vpat_pkg.sv
// Shared state/mode encodings and the PRBS step for the AXI-Stream video pattern generator.
// No timing of its own; used by axis_vpat_gen and axis_vpat_data.
package axis_vpat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FRAME_WAIT = 2'd1,
        ST_SEND       = 2'd2,
        ST_LINE_WAIT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_t;

    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

    // Fibonacci form of x^32+x^22+x^2+x+1, shifting toward the MSB.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/axis_vpat_data.sv
// Pattern datapath: maps beat/line/frame position, latched mode and LFSR state to TDATA.
// Purely combinational; the caller holds its inputs stable while the stream is stalled.
module axis_vpat_data
    import axis_vpat_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic [15:0]            beat,
    input  logic [11:0]            line,
    input  logic [3:0]             frame,
    input  mode_t                  mode,
    input  logic [TDATA_WIDTH-1:0] const_val,
    input  logic [31:0]            lfsr,
    output logic [TDATA_WIDTH-1:0] data
);

    logic [TDATA_WIDTH-1:0] prbs_rep;

    // PRBS word is repeated across wide buses and truncated on the last copy.
    for (genvar i = 0; i < TDATA_WIDTH; i++) begin : g_rep
        assign prbs_rep[i] = lfsr[i % 32];
    end

    always_comb begin
        data = '0;
        case (mode)
            MODE_INCR:  data = TDATA_WIDTH'({frame, line, beat});
            MODE_CONST: data = const_val;
            MODE_CHECK: data = {TDATA_WIDTH{beat[3] ^ line[3]}};
            MODE_PRBS:  data = prbs_rep;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/axis_vpat_gen.sv
// AXI-Stream video test-pattern source; first beat FRAME_GAP+1 cycles after enable is seen in IDLE.
// Beats advance only on TVALID&TREADY; all outputs hold while TREADY is low.
module axis_vpat_gen
    import axis_vpat_pkg::*;
#(
    parameter int TDATA_WIDTH  = 32,
    parameter int PIX_PER_BEAT = 4,
    parameter int H_PIXELS     = 1280,
    parameter int V_LINES      = 1024,
    parameter int LINE_GAP     = 3,
    parameter int FRAME_GAP    = 1000
) (
    input  logic                     M_AXIS_ACLK,
    input  logic                     M_AXIS_ARESETN,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [TDATA_WIDTH-1:0]   const_val,
    output logic                     M_AXIS_TVALID,
    output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TUSER,
    input  logic                     M_AXIS_TREADY,
    output logic [15:0]              frame_cnt,
    output logic                     busy
);

    localparam int          BEATS     = H_PIXELS / PIX_PER_BEAT;
    localparam logic [15:0] LAST_BEAT = 16'(BEATS - 1);
    localparam logic [11:0] LAST_LINE = 12'(V_LINES - 1);

    state_t                 state;
    logic [15:0]            beat;
    logic [11:0]            line;
    logic [31:0]            gap_cnt;
    mode_t                  mode_lat;
    logic [TDATA_WIDTH-1:0] const_lat;
    logic [31:0]            lfsr;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state     <= ST_IDLE;
            beat      <= '0;
            line      <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            mode_lat  <= MODE_INCR;
            const_lat <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_FRAME_WAIT;
                        gap_cnt <= '0;
                    end
                end
                ST_FRAME_WAIT: begin
                    // Pattern settings are captured once per frame so a frame is never mixed.
                    if (gap_cnt == 32'(FRAME_GAP)) begin
                        state     <= ST_SEND;
                        gap_cnt   <= '0;
                        beat      <= '0;
                        line      <= '0;
                        mode_lat  <= mode_t'(mode);
                        const_lat <= const_val;
                        lfsr      <= LFSR_SEED;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                ST_SEND: begin
                    if (M_AXIS_TREADY) begin
                        lfsr <= lfsr_next(lfsr);
                        if (beat == LAST_BEAT) begin
                            beat    <= '0;
                            gap_cnt <= '0;
                            if (line == LAST_LINE) begin
                                line      <= '0;
                                frame_cnt <= frame_cnt + 16'd1;
                                state     <= enable ? ST_FRAME_WAIT : ST_IDLE;
                            end else begin
                                line <= line + 12'd1;
                                if (LINE_GAP > 0) begin
                                    state <= ST_LINE_WAIT;
                                end
                            end
                        end else begin
                            beat <= beat + 16'd1;
                        end
                    end
                end
                ST_LINE_WAIT: begin
                    if (gap_cnt == 32'(LINE_GAP) - 32'd1) begin
                        state   <= ST_SEND;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_vpat_data #(
        .TDATA_WIDTH(TDATA_WIDTH)
    ) u_data (
        .beat      (beat),
        .line      (line),
        .frame     (frame_cnt[3:0]),
        .mode      (mode_lat),
        .const_val (const_lat),
        .lfsr      (lfsr),
        .data      (M_AXIS_TDATA)
    );

    assign M_AXIS_TVALID = (state == ST_SEND);
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (beat == LAST_BEAT);
    assign M_AXIS_TUSER  = M_AXIS_TVALID && (beat == 16'd0) && (line == 12'd0);
    assign M_AXIS_TSTRB  = '1;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_vpat_gen.sv
// Directed bench for axis_vpat_gen: 16x3 frames, 4 pixels/beat, line gap 2 (and 0), frame gap 5.
module tb_axis_vpat_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [1:0]  mode;
    logic [31:0] const_val;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tuser;
    logic        tready;
    logic [15:0] frame_cnt;
    logic        busy;

    logic        enable0;
    logic [1:0]  mode0;
    logic [31:0] const0;
    logic        tvalid0;
    logic [31:0] tdata0;
    logic [3:0]  tstrb0;
    logic        tlast0;
    logic        tuser0;
    logic        tready0;
    logic [15:0] frame_cnt0;
    logic        busy0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_vpat_gen #(
        .TDATA_WIDTH(32), .PIX_PER_BEAT(4), .H_PIXELS(16), .V_LINES(3),
        .LINE_GAP(2), .FRAME_GAP(5)
    ) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .enable(enable), .mode(mode),
        .const_val(const_val), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata),
        .M_AXIS_TSTRB(tstrb), .M_AXIS_TLAST(tlast), .M_AXIS_TUSER(tuser),
        .M_AXIS_TREADY(tready), .frame_cnt(frame_cnt), .busy(busy)
    );

    axis_vpat_gen #(
        .TDATA_WIDTH(32), .PIX_PER_BEAT(4), .H_PIXELS(16), .V_LINES(3),
        .LINE_GAP(0), .FRAME_GAP(5)
    ) dut0 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn), .enable(enable0), .mode(mode0),
        .const_val(const0), .M_AXIS_TVALID(tvalid0), .M_AXIS_TDATA(tdata0),
        .M_AXIS_TSTRB(tstrb0), .M_AXIS_TLAST(tlast0), .M_AXIS_TUSER(tuser0),
        .M_AXIS_TREADY(tready0), .frame_cnt(frame_cnt0), .busy(busy0)
    );

    typedef struct {
        logic [11:0] line;
        logic [15:0] beat;
        logic        last;
        logic        user;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int cyc = 0; cyc < 100 && !tvalid; cyc++) @(negedge clk);
        check(name, 64'(tvalid), 64'd1);
    endtask

    // Consume one frame, checking every beat against the table; stalls must hold outputs.
    task automatic collect(input bit toggle, input int drop_idx, input int chg_idx,
                           input bit exp_const, input logic [3:0] fr);
        int          idx = 0;
        bit          stalled = 0;
        bit          tog = 0;
        logic [33:0] held = '0;
        logic [31:0] exp_d;
        for (int cyc = 0; cyc < 2000 && idx < 12; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check("hold", 64'({tvalid, tdata, tlast, tuser}), 64'({1'b1, held}));
                stalled = 0;
            end
            if (toggle) begin
                tog    = ~tog;
                tready = tog;
            end else begin
                tready = 1'b1;
            end
            if (tvalid) begin
                if (idx == drop_idx) enable = 1'b0;
                if (idx == chg_idx) begin
                    mode      = 2'd1;
                    const_val = 32'hA5A5_A5A5;
                end
                if (tready) begin
                    exp_d = exp_const ? 32'hA5A5_A5A5 : {fr, tbl[idx].line, tbl[idx].beat};
                    check("beat", 64'({tdata, tlast, tuser}),
                          64'({exp_d, tbl[idx].last, tbl[idx].user}));
                    idx++;
                end else begin
                    held    = {tdata, tlast, tuser};
                    stalled = 1;
                end
            end
        end
        check("frame_beats", 64'(idx), 64'd12);
        tready = 1'b1;
    endtask

    initial begin
        int lat;
        int n;

        for (int l = 0; l < 3; l++) begin
            for (int b = 0; b < 4; b++) begin
                tbl[l*4 + b] = '{line: 12'(l), beat: 16'(b), last: (b == 3), user: (l == 0 && b == 0)};
            end
        end

        rstn = 1'b0; enable = 1'b0; mode = 2'd0; const_val = 32'd0; tready = 1'b1;
        enable0 = 1'b0; mode0 = 2'd3; const0 = 32'd0; tready0 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tuser", 64'(tuser), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("tstrb", 64'(tstrb), 64'hF);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Latency and first full frame, TREADY held high
        enable = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!tvalid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd6);
        collect(1'b0, 0, -1, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        check("frame_cnt_1", 64'(frame_cnt), 64'd1);
        check("idle_after_1", 64'({busy, tvalid}), 64'd0);

        // Same frame with TREADY toggling every cycle
        enable = 1'b1;
        collect(1'b1, 0, -1, 1'b0, 4'd1);
        repeat (3) @(negedge clk);
        check("frame_cnt_2", 64'(frame_cnt), 64'd2);

        // Enable dropped at line 1 beat 1: frame still completes
        enable = 1'b1;
        collect(1'b0, 5, -1, 1'b0, 4'd2);
        repeat (3) @(negedge clk);
        check("drop_busy_valid", 64'({busy, tvalid}), 64'd0);
        check("frame_cnt_3", 64'(frame_cnt), 64'd3);

        // Mode change mid-frame takes effect only on the next frame
        enable = 1'b1;
        collect(1'b0, -1, 5, 1'b0, 4'd3);
        collect(1'b0, 0, -1, 1'b1, 4'd4);
        repeat (3) @(negedge clk);
        check("frame_cnt_5", 64'(frame_cnt), 64'd5);

        // LINE_GAP=0, PRBS: back-to-back lines
        enable0 = 1'b1;
        for (int cyc = 0; cyc < 100 && !tvalid0; cyc++) @(negedge clk);
        enable0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("b2b_valid", 64'(tvalid0), 64'd1);
            check("b2b_last", 64'(tlast0), 64'(i % 4 == 3));
            if (i == 0) check("prbs_0", 64'(tdata0), 64'hFFFF_FFFF);
            if (i == 1) check("prbs_1", 64'(tdata0), 64'hFFFF_FFFE);
            @(negedge clk);
        end
        check("b2b_end", 64'({tvalid0, frame_cnt0}), 64'({1'b0, 16'd1}));

        // Reset mid-frame at line 1 beat 2
        mode = 2'd0;
        enable = 1'b1;
        wait_valid("wait_pre_rst");
        n = 0;
        while (tdata[27:0] != 28'h001_0002 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_l1b2", 64'(tdata[27:0]), 64'h001_0002);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 64'(tvalid), 64'd0);
        check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        rstn = 1'b1;
        wait_valid("wait_post_rst");
        check("post_rst_first", 64'({tuser, tdata}), 64'({1'b1, 32'd0}));
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
